// File: rtl/ysyx_23060025_exu_muldiv.sv
// Multi-cycle RV32M multiply/divide unit for the EX stage: shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, with sign fix-up on completion.
module ysyx_23060025_exu_muldiv #(
  parameter int DATA_LEN = 32,
  parameter int CNT_W    = $clog2(DATA_LEN + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush_i,
  input  logic                md_valid_i,
  input  logic [2:0]          md_op_i,
  input  logic [DATA_LEN-1:0] src1_i,
  input  logic [DATA_LEN-1:0] src2_i,
  output logic                md_allowin_o,
  output logic                md_result_valid_o,
  output logic [DATA_LEN-1:0] md_result_o,
  input  logic                next_allowin_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [DATA_LEN-1:0] MIN_NEG  = {1'b1, {(DATA_LEN-1){1'b0}}};
  localparam logic [DATA_LEN-1:0] ALL_ONES = {DATA_LEN{1'b1}};
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DATA_LEN - 1);

  logic [1:0]          state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [2:0]          op_reg;
  logic [DATA_LEN-1:0] a_reg;
  logic [DATA_LEN-1:0] hi_reg;
  logic [DATA_LEN-1:0] lo_reg;
  logic                res_neg_reg;
  logic                src1_neg_reg;
  logic [DATA_LEN-1:0] result_reg;

  logic                accept;
  logic                src1_signed;
  logic                src2_signed;
  logic                src1_neg;
  logic                src2_neg;
  logic [DATA_LEN-1:0] src1_mag;
  logic [DATA_LEN-1:0] src2_mag;
  logic                div_zero;
  logic                div_ovf;
  logic [DATA_LEN-1:0] special_result;

  assign md_allowin_o      = (state_reg == IDLE) | ((state_reg == DONE) & next_allowin_i);
  assign md_result_valid_o = (state_reg == DONE) & ~flush_i;
  assign md_result_o       = result_reg;
  assign accept            = md_valid_i & md_allowin_o & ~flush_i;

  // MULHSU is the only op where the two operands differ in signedness.
  assign src2_signed = (md_op_i == 3'b000) | (md_op_i == 3'b001) |
                       (md_op_i == 3'b100) | (md_op_i == 3'b110);
  assign src1_signed = src2_signed | (md_op_i == 3'b010);
  assign src1_neg    = src1_signed & src1_i[DATA_LEN-1];
  assign src2_neg    = src2_signed & src2_i[DATA_LEN-1];
  assign src1_mag    = src1_neg ? (~src1_i + 1'b1) : src1_i;
  assign src2_mag    = src2_neg ? (~src2_i + 1'b1) : src2_i;

  assign div_zero = md_op_i[2] & (src2_i == '0);
  assign div_ovf  = md_op_i[2] & ~md_op_i[0] & (src1_i == MIN_NEG) & (src2_i == ALL_ONES);

  always_comb begin
    special_result = '0;
    if (div_zero)
      special_result = md_op_i[1] ? src1_i : ALL_ONES;
    else if (div_ovf)
      special_result = md_op_i[1] ? '0 : src1_i;
  end

  logic [DATA_LEN:0]     mul_sum;
  logic [DATA_LEN:0]     div_shift;
  logic [DATA_LEN:0]     div_diff;
  logic [DATA_LEN-1:0]   hi_next;
  logic [DATA_LEN-1:0]   lo_next;
  logic [2*DATA_LEN-1:0] prod_fix;
  logic [DATA_LEN-1:0]   quo_fix;
  logic [DATA_LEN-1:0]   rem_fix;
  logic [DATA_LEN-1:0]   final_result;

  // hi/lo form the product (multiply) or remainder/quotient pair (divide).
  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : '0);
    div_shift = {hi_reg, lo_reg[DATA_LEN-1]};
    div_diff  = div_shift - {1'b0, a_reg};
    if (op_reg[2]) begin
      hi_next = div_diff[DATA_LEN] ? div_shift[DATA_LEN-1:0] : div_diff[DATA_LEN-1:0];
      lo_next = {lo_reg[DATA_LEN-2:0], ~div_diff[DATA_LEN]};
    end else begin
      hi_next = mul_sum[DATA_LEN:1];
      lo_next = {mul_sum[0], lo_reg[DATA_LEN-1:1]};
    end
  end

  always_comb begin
    prod_fix = res_neg_reg ? -{hi_next, lo_next} : {hi_next, lo_next};
    quo_fix  = res_neg_reg ? -lo_next : lo_next;
    rem_fix  = src1_neg_reg ? -hi_next : hi_next;
    case (op_reg)
      3'b000:                 final_result = prod_fix[DATA_LEN-1:0];
      3'b001, 3'b010, 3'b011: final_result = prod_fix[2*DATA_LEN-1:DATA_LEN];
      3'b100, 3'b101:         final_result = quo_fix;
      default:                final_result = rem_fix;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      op_reg       <= '0;
      a_reg        <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      res_neg_reg  <= 1'b0;
      src1_neg_reg <= 1'b0;
      result_reg   <= '0;
    end else if (flush_i) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      result_reg <= '0;
    end else if (accept) begin
      op_reg       <= md_op_i;
      a_reg        <= src2_mag;
      hi_reg       <= '0;
      lo_reg       <= src1_mag;
      res_neg_reg  <= src1_neg ^ src2_neg;
      src1_neg_reg <= src1_neg;
      cnt_reg      <= '0;
      if (div_zero | div_ovf) begin
        state_reg  <= DONE;
        result_reg <= special_result;
      end else begin
        state_reg  <= CALC;
      end
    end else begin
      case (state_reg)
        CALC: begin
          hi_reg  <= hi_next;
          lo_reg  <= lo_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            state_reg  <= DONE;
            result_reg <= final_result;
          end
        end
        DONE: begin
          if (next_allowin_i)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
